hsv_range_detect: RTL and testbench
===================================

HSV_RANGE_DETECT -- requirements
Module: hsv_range_detect

Interface
REQ-001 Parameter CW, default 12, pixel/line counter width in bits.
REQ-002 Parameter MASK_ON, default 24'hFFFFFF, MASK_data value for an in-range pixel; an out-of-range pixel SHALL give 24'h000000.
REQ-003 Port clk  in  1  single clock; all logic SHALL be on its rising edge.
REQ-004 Port rst  in  1  synchronous, active-high reset.
REQ-005 Ports HSV_hsync, HSV_vsync, HSV_de  in  1 each  upstream sync strobes and data enable; HSV_vsync is high between frames.
REQ-006 Port HSV_data  in  24  {H/2 [23:16] (0..179), S [15:8], V [7:0]}.
REQ-007 Ports h_min, h_max, s_min, s_max, v_min, v_max  in  8 each  inclusive thresholds.
REQ-008 Ports MASK_hsync, MASK_vsync, MASK_de  out  1 each  delayed syncs; MASK_data  out  24  binary mask pixel.
REQ-009 Ports bbox_x_min, bbox_x_max, bbox_y_min, bbox_y_max  out  CW each; pix_cnt  out  2*CW; bbox_valid  out  1; frame_done  out  1  one-cycle pulse.

Function
REQ-010 Pipeline SHALL be 2 stages: stage 1 registers the per-channel compare results and the pixel x/y; stage 2 combines them, drives MASK_* and updates the accumulators.
REQ-011 MASK_hsync/vsync/de SHALL equal HSV_hsync/vsync/de delayed exactly 2 cycles; MASK_data SHALL be 0 whenever MASK_de is 0.
REQ-012 S and V SHALL match when min <= value <= max, unsigned; if min > max the channel never matches.
REQ-013 Hue SHALL match when h_min <= H <= h_max if h_min <= h_max; otherwise (wrap-around, e.g. red) it SHALL match when H >= h_min or H <= h_max.
REQ-014 A pixel is in range when HSV_de is 1 and H, S and V all match.
REQ-015 Thresholds SHALL be captured into shadow registers on the HSV_vsync rising edge, and all compares SHALL use only the shadow values, so thresholds stay constant within a frame.
REQ-016 x counter SHALL count HSV_de-high cycles within a line, starting at 0, clear on the HSV_de falling edge, and saturate at 2^CW-1.
REQ-017 y counter SHALL increment on each HSV_de falling edge, clear on the HSV_vsync rising edge, and saturate at 2^CW-1.
REQ-018 FSM states: WAIT_FRAME (reset state; accumulators held cleared, frame_done never asserted) and IN_FRAME.
REQ-019 WAIT_FRAME SHALL go to IN_FRAME on the first frame boundary; IN_FRAME SHALL stay in IN_FRAME.
REQ-020 A frame boundary is the rising edge of the stage-2-aligned vsync (MASK_vsync 0->1).
REQ-021 In IN_FRAME each in-range stage-2 pixel SHALL update the bounding box: x_min/y_min to the minimum, x_max/y_max to the maximum, and pix_cnt += 1, saturating at 2^(2*CW)-1.
REQ-022 On a boundary in IN_FRAME the accumulated values SHALL be copied to the bbox_*/pix_cnt outputs, and frame_done SHALL pulse in the same cycle that the outputs update.
REQ-023 On every boundary the accumulators SHALL reinitialise: x_min/y_min to all ones, x_max/y_max to 0, count to 0.
REQ-024 If an in-range pixel sits in stage 2 on the boundary cycle, it SHALL count toward the new frame.
REQ-025 bbox_valid SHALL be 1 iff the published pix_cnt is nonzero; when 0, all bbox_* outputs SHALL be 0.
REQ-026 bbox_*, pix_cnt and bbox_valid SHALL hold their values between boundaries.

Reset
REQ-027 While rst is 1, every output, pipeline register, counter, shadow threshold and accumulator SHALL be 0 (accumulator minima all ones), with state WAIT_FRAME.
REQ-028 Reset asserted mid-frame SHALL discard partial statistics; the first frame_done after release SHALL follow two boundaries.

Structure
REQ-029 A shared package SHALL hold the FSM state enum, the channel bit-field positions of HSV_data, and MASK_ON.
REQ-030 One sub-module, hsv_chan_cmp, SHALL implement the 8-bit inclusive range compare with a wrap-enable input; it SHALL be instantiated three times, with wrap enabled only for hue.

Verification
REQ-031 Thresholds H 50..70, S/V 100..255; a pixel {60,200,200} with de=1 -> MASK_data=FFFFFF exactly 2 cycles later, syncs delayed 2.
REQ-032 h_min=170, h_max=10: H=175 and H=5 -> mask 1; H=90 -> mask 0.
REQ-033 Frame 16x8, in-range block at x 3..6, y 2..4 -> at the next boundary bbox=(3,6,2,4), pix_cnt=12, bbox_valid=1, frame_done one cycle.
REQ-034 Frame with no in-range pixels -> bbox_valid=0, pix_cnt=0, bbox_* all 0.
REQ-035 Change h_max mid-frame -> no mask change until after the next HSV_vsync rising edge.
REQ-036 Assert rst mid-frame for 1 cycle -> all outputs 0; first frame_done only at the second boundary after release.

Source files
------------

// File: rtl/hsv_range_detect_pkg.sv
// Shared types and constants for the HSV range detector: FSM states, HSV_data
// channel layout and the default mask value for in-range pixels.
package hsv_range_detect_pkg;

  typedef enum logic [0:0] {
    StWaitFrame = 1'b0,
    StInFrame   = 1'b1
  } state_e;

  localparam int unsigned ChanW  = 8;
  localparam int unsigned HueLsb = 16;
  localparam int unsigned SatLsb = 8;
  localparam int unsigned ValLsb = 0;

  localparam logic [23:0] MaskOnDefault = 24'hFFFFFF;

  function automatic logic [ChanW-1:0] chan_field(input logic [23:0] pix,
                                                  input int unsigned lsb);
    return pix[lsb +: ChanW];
  endfunction

endpackage

// File: rtl/hsv_chan_cmp.sv
// Inclusive 8-bit range compare; with wrap enabled an inverted range (min > max)
// matches values outside the gap, otherwise it never matches.
module hsv_chan_cmp
  import hsv_range_detect_pkg::*;
(
  input  logic [ChanW-1:0] value_i,
  input  logic [ChanW-1:0] min_i,
  input  logic [ChanW-1:0] max_i,
  input  logic             wrap_en_i,
  output logic             match_o
);

  logic ge_min;
  logic le_max;

  always_comb begin
    ge_min = (value_i >= min_i);
    le_max = (value_i <= max_i);
    if (min_i <= max_i) begin
      match_o = ge_min & le_max;
    end else begin
      match_o = wrap_en_i & (ge_min | le_max);
    end
  end

endmodule

// File: rtl/hsv_range_detect.sv
// Two-stage HSV threshold mask with per-frame bounding box and pixel count of
// the in-range pixels, published at each frame boundary.
module hsv_range_detect
  import hsv_range_detect_pkg::*;
#(
  parameter int unsigned CW      = 12,
  parameter logic [23:0] MASK_ON = MaskOnDefault
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              HSV_hsync,
  input  logic              HSV_vsync,
  input  logic              HSV_de,
  input  logic [23:0]       HSV_data,
  input  logic [7:0]        h_min,
  input  logic [7:0]        h_max,
  input  logic [7:0]        s_min,
  input  logic [7:0]        s_max,
  input  logic [7:0]        v_min,
  input  logic [7:0]        v_max,
  output logic              MASK_hsync,
  output logic              MASK_vsync,
  output logic              MASK_de,
  output logic [23:0]       MASK_data,
  output logic [CW-1:0]     bbox_x_min,
  output logic [CW-1:0]     bbox_x_max,
  output logic [CW-1:0]     bbox_y_min,
  output logic [CW-1:0]     bbox_y_max,
  output logic [2*CW-1:0]   pix_cnt,
  output logic              bbox_valid,
  output logic              frame_done
);

  localparam int unsigned PW = 2 * CW;
  localparam logic [CW-1:0] CntMax = '1;
  localparam logic [PW-1:0] PixMax = '1;

  // Shadow thresholds, frozen for the whole frame
  logic [7:0] h_min_q, h_max_q, s_min_q, s_max_q, v_min_q, v_max_q;

  logic          vsync_in_q, de_in_q;
  logic          vsync_rise, de_fall;
  logic [CW-1:0] x_cnt_q, x_cnt_d, y_cnt_q, y_cnt_d;
  logic          h_match, s_match, v_match;

  // Stage 1
  logic          s1_hsync_q, s1_vsync_q, s1_de_q;
  logic          s1_h_match_q, s1_s_match_q, s1_v_match_q;
  logic [CW-1:0] s1_x_q, s1_y_q;

  // Stage 2
  logic          mask_hsync_q, mask_vsync_q, mask_de_q;
  logic [23:0]   mask_data_q;
  logic          pix_hit, boundary;

  state_e        state_q;
  logic [CW-1:0] acc_x_min_q, acc_x_max_q, acc_y_min_q, acc_y_max_q;
  logic [PW-1:0] acc_cnt_q;
  logic [CW-1:0] seed_x_min, seed_x_max, seed_y_min, seed_y_max;
  logic [PW-1:0] seed_cnt;
  logic [CW-1:0] upd_x_min, upd_x_max, upd_y_min, upd_y_max;
  logic [PW-1:0] upd_cnt;
  logic          acc_nz;
  logic [CW-1:0] pub_x_min_q, pub_x_max_q, pub_y_min_q, pub_y_max_q;
  logic [PW-1:0] pub_cnt_q;
  logic          pub_valid_q, frame_done_q;

  hsv_chan_cmp u_cmp_h (
    .value_i   (chan_field(HSV_data, HueLsb)),
    .min_i     (h_min_q),
    .max_i     (h_max_q),
    .wrap_en_i (1'b1),
    .match_o   (h_match)
  );

  hsv_chan_cmp u_cmp_s (
    .value_i   (chan_field(HSV_data, SatLsb)),
    .min_i     (s_min_q),
    .max_i     (s_max_q),
    .wrap_en_i (1'b0),
    .match_o   (s_match)
  );

  hsv_chan_cmp u_cmp_v (
    .value_i   (chan_field(HSV_data, ValLsb)),
    .min_i     (v_min_q),
    .max_i     (v_max_q),
    .wrap_en_i (1'b0),
    .match_o   (v_match)
  );

  always_comb begin
    vsync_rise = HSV_vsync & ~vsync_in_q;
    de_fall    = de_in_q & ~HSV_de;

    x_cnt_d = x_cnt_q;
    if (de_fall) begin
      x_cnt_d = '0;
    end else if (HSV_de && (x_cnt_q != CntMax)) begin
      x_cnt_d = x_cnt_q + CW'(1);
    end

    y_cnt_d = y_cnt_q;
    if (vsync_rise) begin
      y_cnt_d = '0;
    end else if (de_fall && (y_cnt_q != CntMax)) begin
      y_cnt_d = y_cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_min_q    <= '0;
      h_max_q    <= '0;
      s_min_q    <= '0;
      s_max_q    <= '0;
      v_min_q    <= '0;
      v_max_q    <= '0;
      vsync_in_q <= 1'b0;
      de_in_q    <= 1'b0;
      x_cnt_q    <= '0;
      y_cnt_q    <= '0;
    end else begin
      if (vsync_rise) begin
        h_min_q <= h_min;
        h_max_q <= h_max;
        s_min_q <= s_min;
        s_max_q <= s_max;
        v_min_q <= v_min;
        v_max_q <= v_max;
      end
      vsync_in_q <= HSV_vsync;
      de_in_q    <= HSV_de;
      x_cnt_q    <= x_cnt_d;
      y_cnt_q    <= y_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_hsync_q   <= 1'b0;
      s1_vsync_q   <= 1'b0;
      s1_de_q      <= 1'b0;
      s1_h_match_q <= 1'b0;
      s1_s_match_q <= 1'b0;
      s1_v_match_q <= 1'b0;
      s1_x_q       <= '0;
      s1_y_q       <= '0;
      mask_hsync_q <= 1'b0;
      mask_vsync_q <= 1'b0;
      mask_de_q    <= 1'b0;
      mask_data_q  <= '0;
    end else begin
      s1_hsync_q   <= HSV_hsync;
      s1_vsync_q   <= HSV_vsync;
      s1_de_q      <= HSV_de;
      s1_h_match_q <= h_match;
      s1_s_match_q <= s_match;
      s1_v_match_q <= v_match;
      s1_x_q       <= x_cnt_q;
      s1_y_q       <= y_cnt_q;
      mask_hsync_q <= s1_hsync_q;
      mask_vsync_q <= s1_vsync_q;
      mask_de_q    <= s1_de_q;
      mask_data_q  <= pix_hit ? MASK_ON : 24'h000000;
    end
  end

  // Boundary is seen the cycle before MASK_vsync rises so that the published
  // statistics and frame_done appear together with the rising MASK_vsync.
  always_comb begin
    pix_hit  = s1_de_q & s1_h_match_q & s1_s_match_q & s1_v_match_q;
    boundary = s1_vsync_q & ~mask_vsync_q;
    acc_nz   = (acc_cnt_q != '0);

    seed_x_min = pix_hit ? s1_x_q : '1;
    seed_y_min = pix_hit ? s1_y_q : '1;
    seed_x_max = pix_hit ? s1_x_q : '0;
    seed_y_max = pix_hit ? s1_y_q : '0;
    seed_cnt   = pix_hit ? PW'(1) : '0;

    upd_x_min = (pix_hit && (s1_x_q < acc_x_min_q)) ? s1_x_q : acc_x_min_q;
    upd_y_min = (pix_hit && (s1_y_q < acc_y_min_q)) ? s1_y_q : acc_y_min_q;
    upd_x_max = (pix_hit && (s1_x_q > acc_x_max_q)) ? s1_x_q : acc_x_max_q;
    upd_y_max = (pix_hit && (s1_y_q > acc_y_max_q)) ? s1_y_q : acc_y_max_q;
    upd_cnt   = (pix_hit && (acc_cnt_q != PixMax)) ? acc_cnt_q + PW'(1) : acc_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StWaitFrame;
      acc_x_min_q  <= '1;
      acc_y_min_q  <= '1;
      acc_x_max_q  <= '0;
      acc_y_max_q  <= '0;
      acc_cnt_q    <= '0;
      pub_x_min_q  <= '0;
      pub_x_max_q  <= '0;
      pub_y_min_q  <= '0;
      pub_y_max_q  <= '0;
      pub_cnt_q    <= '0;
      pub_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      unique case (state_q)
        StWaitFrame: begin
          if (boundary) begin
            state_q     <= StInFrame;
            acc_x_min_q <= seed_x_min;
            acc_y_min_q <= seed_y_min;
            acc_x_max_q <= seed_x_max;
            acc_y_max_q <= seed_y_max;
            acc_cnt_q   <= seed_cnt;
          end else begin
            acc_x_min_q <= '1;
            acc_y_min_q <= '1;
            acc_x_max_q <= '0;
            acc_y_max_q <= '0;
            acc_cnt_q   <= '0;
          end
        end
        StInFrame: begin
          if (boundary) begin
            frame_done_q <= 1'b1;
            pub_valid_q  <= acc_nz;
            pub_cnt_q    <= acc_cnt_q;
            pub_x_min_q  <= acc_nz ? acc_x_min_q : '0;
            pub_x_max_q  <= acc_nz ? acc_x_max_q : '0;
            pub_y_min_q  <= acc_nz ? acc_y_min_q : '0;
            pub_y_max_q  <= acc_nz ? acc_y_max_q : '0;
            acc_x_min_q  <= seed_x_min;
            acc_y_min_q  <= seed_y_min;
            acc_x_max_q  <= seed_x_max;
            acc_y_max_q  <= seed_y_max;
            acc_cnt_q    <= seed_cnt;
          end else begin
            acc_x_min_q <= upd_x_min;
            acc_y_min_q <= upd_y_min;
            acc_x_max_q <= upd_x_max;
            acc_y_max_q <= upd_y_max;
            acc_cnt_q   <= upd_cnt;
          end
        end
        default: state_q <= StWaitFrame;
      endcase
    end
  end

  assign MASK_hsync = mask_hsync_q;
  assign MASK_vsync = mask_vsync_q;
  assign MASK_de    = mask_de_q;
  assign MASK_data  = mask_data_q;
  assign bbox_x_min = pub_x_min_q;
  assign bbox_x_max = pub_x_max_q;
  assign bbox_y_min = pub_y_min_q;
  assign bbox_y_max = pub_y_max_q;
  assign pix_cnt    = pub_cnt_q;
  assign bbox_valid = pub_valid_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_hsv_range_detect.sv
// Randomised frame stimulus against a frame-level reference model; expected
// per-cycle outputs and per-frame statistics are queued and checked by a monitor.
module tb_hsv_range_detect;

  localparam int unsigned CW = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          hs, vs, de;
  logic [23:0]   data;
  logic [7:0]    th_hmin, th_hmax, th_smin, th_smax, th_vmin, th_vmax;
  logic          m_hs, m_vs, m_de;
  logic [23:0]   m_data;
  logic [CW-1:0] bx_min, bx_max, by_min, by_max;
  logic [2*CW-1:0] p_cnt;
  logic          b_valid, f_done;

  hsv_range_detect #(.CW(CW), .MASK_ON(24'hFFFFFF)) dut (
    .clk        (clk),
    .rst        (rst),
    .HSV_hsync  (hs),
    .HSV_vsync  (vs),
    .HSV_de     (de),
    .HSV_data   (data),
    .h_min      (th_hmin),
    .h_max      (th_hmax),
    .s_min      (th_smin),
    .s_max      (th_smax),
    .v_min      (th_vmin),
    .v_max      (th_vmax),
    .MASK_hsync (m_hs),
    .MASK_vsync (m_vs),
    .MASK_de    (m_de),
    .MASK_data  (m_data),
    .bbox_x_min (bx_min),
    .bbox_x_max (bx_max),
    .bbox_y_min (by_min),
    .bbox_y_max (by_max),
    .pix_cnt    (p_cnt),
    .bbox_valid (b_valid),
    .frame_done (f_done)
  );

  typedef struct packed {
    logic        hs, vs, de;
    logic [23:0] data;
    logic        fd;
    logic        clr;
  } exp_t;

  typedef struct packed {
    logic [11:0] xmin, xmax, ymin, ymax;
    logic [23:0] cnt;
    logic        valid;
  } stats_t;

  exp_t   eq[$];
  stats_t sq[$];

  int n_checks = 0;
  int n_pass   = 0;
  bit mon_en   = 1'b0;

  // Reference model state
  int sh_hmin, sh_hmax, sh_smin, sh_smax, sh_vmin, sh_vmax;
  bit prev_vs, seen_bnd;
  int f_xmin, f_xmax, f_ymin, f_ymax, f_cnt;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic bit hue_ok(input int h, input int lo, input int hi);
    if (lo <= hi) return (h >= lo) && (h <= hi);
    return (h >= lo) || (h <= hi);
  endfunction

  function automatic bit chan_ok(input int v, input int lo, input int hi);
    return (lo <= hi) && (v >= lo) && (v <= hi);
  endfunction

  function automatic void frame_clear();
    f_xmin = 1 << 30; f_xmax = -1; f_ymin = 1 << 30; f_ymax = -1; f_cnt = 0;
  endfunction

  task automatic drive(input bit r, input bit h, input bit v, input bit d,
                       input logic [23:0] px, input int x, input int y);
    exp_t   e;
    stats_t s;
    bit     ok;
    rst = r; hs = h; vs = v; de = d; data = px;
    e = '0;
    if (r) begin
      e.clr = 1'b1;
      if (eq.size() > 0) begin
        if (eq[eq.size()-1].fd) void'(sq.pop_back());
        eq[eq.size()-1] = e;
      end else begin
        eq.push_back(e);
      end
      eq.push_back(e);
      sh_hmin = 0; sh_hmax = 0; sh_smin = 0; sh_smax = 0; sh_vmin = 0; sh_vmax = 0;
      prev_vs = 1'b0; seen_bnd = 1'b0;
      frame_clear();
    end else begin
      ok = d && hue_ok(int'(px[23:16]), sh_hmin, sh_hmax) &&
           chan_ok(int'(px[15:8]), sh_smin, sh_smax) && chan_ok(int'(px[7:0]), sh_vmin, sh_vmax);
      e.hs = h; e.vs = v; e.de = d;
      e.data = ok ? 24'hFFFFFF : 24'h000000;
      if (v && !prev_vs) begin
        e.fd = seen_bnd;
        if (seen_bnd) begin
          s = '0;
          s.cnt = f_cnt[23:0];
          s.valid = (f_cnt != 0);
          if (f_cnt != 0) begin
            s.xmin = f_xmin[11:0]; s.xmax = f_xmax[11:0];
            s.ymin = f_ymin[11:0]; s.ymax = f_ymax[11:0];
          end
          sq.push_back(s);
        end
        frame_clear();
        seen_bnd = 1'b1;
        sh_hmin = th_hmin; sh_hmax = th_hmax; sh_smin = th_smin;
        sh_smax = th_smax; sh_vmin = th_vmin; sh_vmax = th_vmax;
      end
      if (ok && seen_bnd) begin
        if (x < f_xmin) f_xmin = x;
        if (x > f_xmax) f_xmax = x;
        if (y < f_ymin) f_ymin = y;
        if (y > f_ymax) f_ymax = y;
        f_cnt++;
      end
      prev_vs = v;
      eq.push_back(e);
    end
    @(posedge clk);
    #2;
  endtask

  function automatic logic [23:0] pixel(input int mode, input int x, input int y);
    logic [7:0] hh;
    case (mode)
      1: return ((x >= 3) && (x <= 6) && (y >= 2) && (y <= 4)) ? 24'h3CC8C8 : 24'h3C32C8;
      2: return {8'($urandom_range(0, 179)), 8'h00, 8'($urandom)};
      3: begin
        case (x % 3)
          0: hh = 8'd175;
          1: hh = 8'd5;
          default: hh = 8'd90;
        endcase
        return {hh, 8'd200, 8'd200};
      end
      default: return {8'($urandom_range(0, 179)), 8'($urandom), 8'($urandom)};
    endcase
  endfunction

  task automatic vsync_gap();
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b1, 1'b0, 24'h0, 0, 0);
    for (int i = 0; i < 2; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 24'h0, 0, 0);
  endtask

  // evt 1: change h_max on evt_line; evt 2: one-cycle reset mid-line on evt_line
  task automatic frame(input int w, input int hgt, input int mode, input int evt_line,
                       input int evt);
    for (int y = 0; y < hgt; y++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0, 24'h0, 0, y);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 24'h0, 0, y);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 24'h0, 0, y);
      if (y == evt_line && evt == 1) th_hmax = 8'($urandom_range(0, 179));
      for (int x = 0; x < w; x++) begin
        drive((y == evt_line && evt == 2 && x == w / 2), 1'b0, 1'b0, 1'b1,
              pixel(mode, x, y), x, y);
      end
      for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 24'h0, 0, y);
    end
  endtask

  task automatic set_th(input int hmin, input int hmax, input int smin, input int smax,
                        input int vmin, input int vmax);
    th_hmin = 8'(hmin); th_hmax = 8'(hmax); th_smin = 8'(smin);
    th_smax = 8'(smax); th_vmin = 8'(vmin); th_vmax = 8'(vmax);
  endtask

  task automatic rand_th();
    set_th($urandom_range(0, 179), $urandom_range(0, 179), $urandom_range(0, 160),
           $urandom_range(60, 255), $urandom_range(0, 160), $urandom_range(60, 255));
  endtask

  // Monitor: one expected entry per clock, statistics popped on frame_done
  initial begin
    exp_t   e;
    stats_t cur;
    cur = '0;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        if (eq.size() == 0) begin
          check("exp_queue", 128'(eq.size()), 128'd1);
        end else begin
          e = eq.pop_front();
          check("mask", {m_hs, m_vs, m_de, m_data}, {e.hs, e.vs, e.de, e.data});
          check("frame_done", f_done, e.fd);
          if (e.clr) cur = '0;
          if (e.fd) begin
            if (sq.size() == 0) check("stats_queue", 128'(sq.size()), 128'd1);
            else cur = sq.pop_front();
          end
          check("stats", {bx_min, bx_max, by_min, by_max, p_cnt, b_valid}, cur);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; hs = 1'b0; vs = 1'b0; de = 1'b0; data = '0;
    set_th(0, 0, 0, 0, 0, 0);
    frame_clear();
    @(posedge clk);
    #2;
    mon_en = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 24'h0, 0, 0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 24'h0, 0, 0);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 24'h0, 0, 0);

    // In-range block at x 3..6, y 2..4
    set_th(50, 70, 100, 255, 100, 255);
    vsync_gap();
    frame(16, 8, 1, -1, 0);

    // Wrap-around hue 170..10
    set_th(170, 10, 100, 255, 100, 255);
    vsync_gap();
    check("bbox_block", {bx_min, bx_max, by_min, by_max, p_cnt, b_valid},
          {12'd3, 12'd6, 12'd2, 12'd4, 24'd12, 1'b1});
    frame(12, 4, 3, -1, 0);

    // No pixel can pass the saturation window
    set_th(0, 179, 100, 255, 0, 255);
    vsync_gap();
    frame(16, 8, 2, -1, 0);
    rand_th();
    vsync_gap();
    check("bbox_empty", {bx_min, bx_max, by_min, by_max, p_cnt, b_valid}, 128'd0);

    // Threshold change mid-frame must not take effect until next frame
    frame(16, 8, 0, 3, 1);
    rand_th();
    vsync_gap();

    // Reset mid-frame; first frame_done only at the second boundary after release
    frame(16, 8, 0, 4, 2);
    rand_th();
    vsync_gap();
    frame(16, 8, 0, -1, 0);
    rand_th();
    vsync_gap();

    for (int f = 0; f < 4; f++) begin
      frame(20, 8, 0, -1, 0);
      rand_th();
      vsync_gap();
    end
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 24'h0, 0, 0);
    mon_en = 1'b0;
    check("stats_drain", 128'(sq.size()), 128'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
